// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_slave
// Description : APB register slave with N_REGS registers, byte-lane strobes,
//               a programmable number of PREADY-low wait cycles, and error
//               responses for out-of-range or misaligned addresses.
//               Optional macro APB_SLV_PROT_EN: unprivileged writes
//               (PPROT[0]=0) are refused with PSLVERR=1.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
  parameter int N_REGS      = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_STATES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [2:0]              PPROT,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int         NUM_LANES = DATA_WIDTH / 8;
  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam int         SEL_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_LANES-1:0]    strb_q;
  logic [DATA_WIDTH-1:0]   regs_q [N_REGS];

  logic                    setup_req;
  logic                    capture;
  logic [IDX_W-1:0]        idx;
  logic [SEL_W-1:0]        sel;
  logic                    range_err;
  logic                    align_err;
  logic                    prot_err;
  logic                    err;
  logic                    commit;

  // A new transfer is announced by the APB setup phase.
  assign setup_req = PSEL & ~PENABLE;
  // Bus fields are latched only on the edge that enters SETUP.
  assign capture   = (state_d == SETUP);

  assign idx       = addr_q[ADDR_WIDTH-1:2];
  assign sel       = idx[SEL_W-1:0];
  assign range_err = (32'(idx) >= 32'(N_REGS));
  assign align_err = |addr_q[1:0];

`ifdef APB_SLV_PROT_EN
  logic priv_q;
  logic unused_pprot;
  // Only the privileged bit matters; the other protection bits are unused.
  assign unused_pprot = ^PPROT[2:1];
  assign prot_err     = write_q & ~priv_q;

  // Latch the privilege bit alongside the rest of the transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      priv_q <= 1'b0;
    end else if (capture) begin
      priv_q <= PPROT[0];
    end
  end
`else
  logic unused_pprot;
  // Protection checking is compiled out: PPROT has no effect.
  assign unused_pprot = ^PPROT;
  assign prot_err     = 1'b0;
`endif

  assign err    = range_err | align_err | prot_err;
  assign commit = (state_q == ACCESS) & write_q & ~err;

  // State, wait counter and captured transfer fields.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
    end
  end

  // Next-state and wait-counter logic; a PSEL drop aborts before ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (setup_req) state_d = SETUP;
      end
      SETUP: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = setup_req ? SETUP : IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Response outputs: all zero except during the single ACCESS cycle.
  always_comb begin
    PREADY  = (state_q == ACCESS);
    PSLVERR = PREADY & err;
    PRDATA  = '0;
    if (PREADY && !write_q && !err) PRDATA = regs_q[sel];
  end

  // Register file: byte-lane merge of the captured write data in ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int r = 0; r < N_REGS; r++) regs_q[r] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (strb_q[b]) regs_q[sel][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_reg_slave
// Description : Self-checking bench for apb_reg_slave: table-driven transfers
//               with a response scoreboard, plus hand sequences for held-bus
//               capture, IDLE protocol violation, PSEL abort, protection and
//               reset during a wait state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

  localparam int WS = 2;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [6:0]  PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb_reg_slave #(
    .N_REGS     (8),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (7),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PADDR  (PADDR),
    .PPROT  (PPROT),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PREADY (PREADY),
    .PRDATA (PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  sb_t         sb_q [$];
  sb_t         mon_e;
  vec_t        vecs [15];
  logic [31:0] model [8];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [6:0] addr, input logic [31:0] d,
                                      input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[addr[4:2]][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // One APB transfer, called at a negedge; returns at the negedge of PREADY.
  task automatic xfer(input string name, input logic wr, input logic [6:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rdata, input logic exp_err, input bit mutate);
    sb_t e;
    int  lat;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat = 0;
    while (!PREADY && lat < 20) begin
      @(negedge PCLK);
      lat++;
      if (mutate && !PREADY) begin
        PADDR = addr + 7'h04; PWDATA = ~wdata; PSTRB = 4'h0; PWRITE = ~wr; PPROT = ~prot;
      end
    end
    if (PREADY) begin
      check({name, "_latency"}, 32'(lat), 32'(WS + 1));
    end else begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: no PREADY after %0d cycles, required within %0d", name, lat, WS + 1);
      void'(sb_q.pop_back());
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Scoreboard: every PREADY pulse must match the oldest pending transfer.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (PREADY) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_pready: got PREADY=1 with no transfer pending, required 0");
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_prdata"}, PRDATA, mon_e.rdata);
          check({mon_e.name, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, mon_e.err});
        end
      end else if (PSLVERR || PRDATA != 32'h0) begin
        n_vec++;
        n_fail++;
        $display("FAIL idle_outputs: got PSLVERR=%0b PRDATA=0x%08h with PREADY=0, required 0/0",
                 PSLVERR, PRDATA);
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 7'h08, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 7'h08, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 7'h04, 32'h11223344, 4'hF, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 7'h04, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 7'h04, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 7'h20, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 7'h02, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 7'h20, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 7'h1C, 32'h12345678, 4'h0, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 7'h1C, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 7'h1C, 32'hCAFEF00D, 4'h8, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 7'h1C, 32'h00000000, 4'h0, 32'hCA000000, 1'b0};
    vecs[12] = '{1'b1, 7'h03, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 7'h00, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 7'h7C, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    for (int i = 0; i < 8; i++) model[i] = 32'h0;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 7'h0; PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'b000;
    repeat (3) @(negedge PCLK);
    check("reset_pready", {31'b0, PREADY}, 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
    PRESET = 1'b0;

    // Table of back-to-back transfers.
    for (int i = 0; i < 15; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           3'b001, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
      if (vecs[i].wr && !vecs[i].exp_err) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
    end

    // Bus fields changed after SETUP must not affect the transfer.
    xfer("hold_wr", 1'b1, 7'h10, 32'h0BADF00D, 4'hF, 3'b001, 32'h0, 1'b0, 1'b1);
    model_write(7'h10, 32'h0BADF00D, 4'hF);
    xfer("hold_rd10", 1'b0, 7'h10, 32'h0, 4'h0, 3'b001, 32'h0BADF00D, 1'b0, 1'b0);
    xfer("hold_rd14", 1'b0, 7'h14, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, 1'b0);

    // PENABLE=1 while idle is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 7'h08; PWRITE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check($sformatf("idle_penable%0d_pready", k), {31'b0, PREADY}, 32'h0);
    end

    // PSEL dropped during WAIT aborts the write.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 7'h00; PWRITE = 1'b1;
    PWDATA = 32'h5; PSTRB = 4'hF; PPROT = 3'b001;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("drop_pready", {31'b0, PREADY}, 32'h0);
    xfer("drop_rd00", 1'b0, 7'h00, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, 1'b0);

`ifdef APB_SLV_PROT_EN
    xfer("prot_wr_user", 1'b1, 7'h00, 32'h1, 4'hF, 3'b000, 32'h0, 1'b1, 1'b0);
    xfer("prot_rd_user", 1'b0, 7'h00, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0);
    xfer("prot_wr_priv", 1'b1, 7'h00, 32'h1, 4'hF, 3'b001, 32'h0, 1'b0, 1'b0);
    model_write(7'h00, 32'h1, 4'hF);
    xfer("prot_rd_priv", 1'b0, 7'h00, 32'h0, 4'h0, 3'b000, 32'h1, 1'b0, 1'b0);
`else
    xfer("noprot_wr", 1'b1, 7'h00, 32'h1, 4'hF, 3'b000, 32'h0, 1'b0, 1'b0);
    model_write(7'h00, 32'h1, 4'hF);
    xfer("noprot_rd", 1'b0, 7'h00, 32'h0, 4'h0, 3'b000, 32'h1, 1'b0, 1'b0);
`endif

    // Full register sweep against the model.
    for (int i = 0; i < 8; i++) begin
      xfer($sformatf("sweep_r%0d", i), 1'b0, 7'(i * 4), 32'h0, 4'h0, 3'b001,
           model[i], 1'b0, 1'b0);
    end

    // Reset asserted during WAIT of a write to 0x0C.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 7'h0C; PWRITE = 1'b1;
    PWDATA = 32'h12345678; PSTRB = 4'hF; PPROT = 3'b001;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_wait_pready", {31'b0, PREADY}, 32'h0);
    check("rst_wait_prdata", PRDATA, 32'h0);
    check("rst_wait_pslverr", {31'b0, PSLVERR}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("rst_hold_pready", {31'b0, PREADY}, 32'h0);
    PRESET = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    xfer("post_rst_rd0c", 1'b0, 7'h0C, 32'h0, 4'h0, 3'b001, model[3], 1'b0, 1'b0);
    xfer("post_rst_rd08", 1'b0, 7'h08, 32'h0, 4'h0, 3'b001, model[2], 1'b0, 1'b0);

    repeat (3) @(negedge PCLK);
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
